// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Per-button conditioning between raw board push-buttons and the LED counter.
// Each bit is handled independently: optional polarity inversion, two-flop
// synchroniser, debounce filter, registered press/release edge pulses and a
// hold-to-repeat pulse generator.
//
// Parameters:
//   WIDTH           number of buttons (one independent channel per bit)
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a new level (>= 1)
//   REPEAT_DELAY    cycles from the press pulse to the first repeat pulse (>= 1)
//   REPEAT_PERIOD   cycles between subsequent repeat pulses (>= 1)
//   INVERT          1 = pads are active-low
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset, clears every register
//   btn          raw asynchronous button pads
//   btn_level    debounced pressed level (1 = pressed)
//   btn_press    one-cycle pulse when btn_level first reads 1
//   btn_release  one-cycle pulse when btn_level first reads 0
//   btn_repeat   one-cycle auto-repeat pulses while btn_level stays 1
// -----------------------------------------------------------------------------
module btn_conditioner #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 3125000,
    parameter int INVERT          = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release,
    output logic [WIDTH-1:0] btn_repeat
);

    localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW      = $clog2(REP_MAX + 1);

    localparam logic          INV   = (INVERT != 0);
    localparam logic [DW:0]   DEB_L = DEBOUNCE_CYCLES[DW:0];
    localparam logic [HW:0]   DEL_L = REPEAT_DELAY[HW:0];
    localparam logic [HW:0]   PER_L = REPEAT_PERIOD[HW:0];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit

        logic          raw;
        logic          s1_q, s2_q;
        logic [DW-1:0] dcnt_q, dcnt_d;
        logic [DW:0]   dinc;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
        logic [HW-1:0] hcnt_q, hcnt_d;
        logic [HW:0]   hinc;
        logic          armed_q, armed_d;
        logic          repeat_q, repeat_d;

        assign raw = btn[i] ^ INV;

        // Debounce: count cycles where the synchronised input disagrees with
        // the accepted level; any agreement restarts the count.
        always_comb begin
            dinc      = {1'b0, dcnt_q} + {{DW{1'b0}}, 1'b1};
            dcnt_d    = '0;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (s2_q != level_q) begin
                if (dinc == DEB_L) begin
                    level_d   = s2_q;
                    press_d   = s2_q;
                    release_d = ~s2_q;
                end else begin
                    dcnt_d = dinc[DW-1:0];
                end
            end
        end

        // Repeat: hcnt only advances while the level is 1 now and stays 1 on
        // this edge, so it is zero at the press edge and cleared on release.
        // armed_q selects the initial delay versus the steady repeat period;
        // hcnt reloads on every repeat so it can never wrap.
        always_comb begin
            hinc     = {1'b0, hcnt_q} + {{HW{1'b0}}, 1'b1};
            hcnt_d   = '0;
            armed_d  = 1'b0;
            repeat_d = 1'b0;
            if (level_q && level_d) begin
                hcnt_d  = hinc[HW-1:0];
                armed_d = armed_q;
                if (hinc == (armed_q ? PER_L : DEL_L)) begin
                    hcnt_d   = '0;
                    armed_d  = 1'b1;
                    repeat_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q      <= 1'b0;
                s2_q      <= 1'b0;
                dcnt_q    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                hcnt_q    <= '0;
                armed_q   <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                s1_q      <= raw;
                s2_q      <= s1_q;
                dcnt_q    <= dcnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                hcnt_q    <= hcnt_d;
                armed_q   <= armed_d;
                repeat_q  <= repeat_d;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_repeat[i]  = repeat_q;

    end : g_bit

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn = 2'b00;
    logic [1:0] btn_n = 2'b11;
    logic [1:0] lvl, prs, rel, rpt;
    logic [1:0] lvl_n, prs_n, rel_n, rpt_n;
    int         n_checks = 0;
    int         n_pass = 0;
    bit         inv_idle = 1'b1;

    always #5 clk = ~clk;

    btn_conditioner #(
        .WIDTH(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .INVERT(0)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn),
        .btn_level(lvl), .btn_press(prs), .btn_release(rel), .btn_repeat(rpt)
    );

    btn_conditioner #(
        .WIDTH(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .INVERT(1)
    ) dut_inv (
        .clk(clk), .rst(rst), .btn(btn_n),
        .btn_level(lvl_n), .btn_press(prs_n), .btn_release(rel_n), .btn_repeat(rpt_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_main(input string t, input int e,
                               input logic [1:0] l, input logic [1:0] p,
                               input logic [1:0] r, input logic [1:0] q);
        check($sformatf("%s e%0d level", t, e), 32'(lvl), 32'(l));
        check($sformatf("%s e%0d press", t, e), 32'(prs), 32'(p));
        check($sformatf("%s e%0d release", t, e), 32'(rel), 32'(r));
        check($sformatf("%s e%0d repeat", t, e), 32'(rpt), 32'(q));
        if (inv_idle)
            check($sformatf("%s e%0d inv idle", t, e),
                  32'({lvl_n, prs_n, rel_n, rpt_n}), 32'h0);
    endtask

    task automatic expect_inv(input string t, input int e,
                              input logic [1:0] l, input logic [1:0] p);
        check($sformatf("%s e%0d inv level", t, e), 32'(lvl_n), 32'(l));
        check($sformatf("%s e%0d inv press", t, e), 32'(prs_n), 32'(p));
        check($sformatf("%s e%0d inv rel/rpt", t, e), 32'({rel_n, rpt_n}), 32'h0);
    endtask

    function automatic logic in_list(input int e, input int a, input int b,
                                     input int c, input int d, input int f);
        return (e == a) || (e == b) || (e == c) || (e == d) || (e == f);
    endfunction

    initial begin
        // 1: reset with both buttons held, then re-acceptance as a press
        rst = 1'b1;
        btn = 2'b11;
        for (int e = -3; e < 0; e++) begin
            tick();
            expect_main("t1 rst", e, 2'b00, 2'b00, 2'b00, 2'b00);
        end
        rst = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            tick();
            expect_main("t1 held", e, (e >= 5) ? 2'b11 : 2'b00,
                        (e == 5) ? 2'b11 : 2'b00, 2'b00, 2'b00);
        end
        btn = 2'b00;
        for (int e = 0; e <= 7; e++) begin
            tick();
            expect_main("t1 rel", e, (e < 5) ? 2'b11 : 2'b00, 2'b00,
                        (e == 5) ? 2'b11 : 2'b00, 2'b00);
        end

        // 2+4: bit 0 held, repeats at P+10, +13, +16, +19, then release
        for (int e = 0; e <= 30; e++) begin
            btn = (e <= 20) ? 2'b01 : 2'b00;
            tick();
            expect_main("t2 hold", e,
                        (e >= 5 && e < 26) ? 2'b01 : 2'b00,
                        (e == 5) ? 2'b01 : 2'b00,
                        (e == 26) ? 2'b01 : 2'b00,
                        in_list(e, 15, 18, 21, 24, -1) ? 2'b01 : 2'b00);
        end

        // 3: bounce (3 high, 1 low) x4, then steady high from edge 16
        for (int e = 0; e <= 22; e++) begin
            btn = (e < 16 && (e % 4) == 3) ? 2'b00 : 2'b01;
            tick();
            expect_main("t3 bounce", e, (e >= 21) ? 2'b01 : 2'b00,
                        (e == 21) ? 2'b01 : 2'b00, 2'b00, 2'b00);
        end
        btn = 2'b00;
        for (int e = 0; e <= 7; e++) begin
            tick();
            expect_main("t3 rel", e, (e < 5) ? 2'b01 : 2'b00, 2'b00,
                        (e == 5) ? 2'b01 : 2'b00, 2'b00);
        end

        // 5: both pressed together, bit 1 released mid-hold, then reset mid-hold
        for (int e = 0; e <= 28; e++) begin
            btn = (e <= 15) ? 2'b11 : 2'b01;
            tick();
            expect_main("t5 both", e,
                        {(e >= 5 && e < 21), (e >= 5)},
                        (e == 5) ? 2'b11 : 2'b00,
                        (e == 21) ? 2'b10 : 2'b00,
                        {in_list(e, 15, 18, -1, -1, -1), in_list(e, 15, 18, 21, 24, 27)});
        end
        rst = 1'b1;
        btn = 2'b00;
        for (int e = 29; e <= 30; e++) begin
            tick();
            expect_main("t5 rst", e, 2'b00, 2'b00, 2'b00, 2'b00);
        end
        rst = 1'b0;
        for (int e = 0; e <= 7; e++) begin
            tick();
            expect_main("t5 idle", e, 2'b00, 2'b00, 2'b00, 2'b00);
        end

        // 6: active-low instance, pads idle high, btn[1] pulled low
        inv_idle = 1'b0;
        btn_n = 2'b01;
        for (int e = 0; e <= 7; e++) begin
            tick();
            expect_inv("t6 inv", e, (e >= 5) ? 2'b10 : 2'b00, (e == 5) ? 2'b10 : 2'b00);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
